mem_seq_ctrl: RTL and testbench
===============================

// Module: mem_seq_ctrl
// PURPOSE
//  Clocked sequencer for the two-memory datapath (memory A, memory B, address counters A/B, pair operand latches).
//  Loads N_WORDS input words into A, then reads A in pairs and writes N_WORDS/2 results into B.
//  Replaces count-decoded control with an FSM plus handshakes: start/done and in_valid/in_ready.
// PARAMETERS
//  N_WORDS  8  words loaded into A per run; must be even and >= 2
//  CNT_W    $clog2(N_WORDS)  width of internal word and pair counters
// PORTS
//  clk       in   1  single clock; all state updates on rising edge
//  rst       in   1  synchronous, active-low reset
//  start     in   1  run request; sampled only in IDLE
//  in_valid  in   1  input word present on datapath bus
//  in_ready  out  1  controller accepts word this cycle (LOAD only)
//  wea       out  1  write enable, memory A
//  inca      out  1  increment address counter A
//  clr_a     out  1  clear address counter A to 0
//  ld_x      out  1  latch A read data into operand X
//  ld_y      out  1  latch A read data into operand Y
//  web       out  1  write enable, memory B (ALU result)
//  incb      out  1  increment address counter B
//  clr_b     out  1  clear address counter B to 0
//  busy      out  1  high in every state except IDLE
//  done      out  1  one-cycle pulse at run completion
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=IDLE, counters=0, every output 0. Applies mid-run; the run is abandoned.
//  - All outputs are decoded from registered state; no output depends combinationally on start.
//  - in_ready = (state==LOAD). wea/inca in LOAD = in_valid. A-memory read data is combinational from address A.
//  - States and transitions:
//    IDLE: start=1 -> CLR; start ignored in every other state.
//    CLR:  clr_a=clr_b=1 for one cycle; wcnt<=0; -> LOAD.
//    LOAD: on in_valid: wea=inca=1, wcnt++; when wcnt==N_WORDS-1 and in_valid -> RWND. in_valid=0 stalls in LOAD with no writes.
//    RWND: clr_a=1 for one cycle; pcnt<=0; -> RDX.
//    RDX:  ld_x=1, inca=1 -> RDY.
//    RDY:  ld_y=1, inca=1 -> WRB.
//    WRB:  web=1 -> NXT.
//    NXT:  incb=1, pcnt++; -> DONE if pcnt==N_WORDS/2-1, else RDX.
//    DONE: done=1 for one cycle -> IDLE.
//  - in_valid outside LOAD is ignored: in_ready=0 and no wea.
//  - Counters never wrap; wcnt is compared with N_WORDS-1 and pcnt with N_WORDS/2-1 (CNT_W bits, unsigned).
//  - Latency with in_valid held high: done is asserted 3+N_WORDS+2*N_WORDS cycles after the cycle start is sampled (27 for N_WORDS=8).
//  - Per-run counts: wea=N_WORDS, inca=2*N_WORDS, web=incb=N_WORDS/2, clr_a=2, clr_b=1.
// CONFIGURATION
//  MEM_SEQ_AUTO_RESTART_EN defined:
//    DONE -> CLR directly; done still pulses; busy stays high.
//    Runs repeat until rst; start is only needed for the first run.
//  MEM_SEQ_AUTO_RESTART_EN undefined: DONE -> IDLE as above.
// STRUCTURE
//  - Package mem_seq_pkg holds:
//    state enum {IDLE, CLR, LOAD, RWND, RDX, RDY, WRB, NXT, DONE} (4-bit encoding);
//    default N_WORDS localparam.
//  - Sub-module mem_seq_cnt: CNT_W-bit up-counter with sync clr, inc, and terminal-count compare.
//    Instantiated twice: wcnt, pcnt.
//  - Output decode is one case block on state.
// TESTING
//  1. rst=0 for 2 cycles, then rst=1, start=0 -> all outputs 0, busy=0, indefinitely.
//  2. start pulse, in_valid=1 throughout, N=8 -> wea high exactly 8 cycles; web/incb each 4 pulses alternating; done at cycle 27.
//  3. In LOAD, drop in_valid for 3 cycles after the 4th word -> no wea/inca while low; done delayed by exactly 3 cycles.
//  4. start=1 held and in_valid toggled during read phase -> no second run begins, no extra wea; single done, then IDLE.
//  5. rst=0 asserted in WRB of pair 2 -> next cycle all outputs 0, state IDLE; fresh start gives a full clean run.
//  6. MEM_SEQ_AUTO_RESTART_EN, one start -> CLR follows each done; 3 consecutive runs each with 8 wea and 4 web.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: state encoding and default size shared by
// the two-memory sequencer and its counters.
package mem_seq_pkg;

  localparam int N_WORDS_DFLT = 8;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LOAD,
    RWND,
    RDX,
    RDY,
    WRB,
    NXT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_seq_cnt.sv
// mem_seq_cnt: saturating up-counter with synchronous clear
// and terminal-count compare against a supplied last value.
module mem_seq_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] q;

  // Holds at the terminal value so the count never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !tc) begin
      q <= q + CNT_W'(1);
    end
  end

  assign tc = (q == last);

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: load N words into A, then pairwise read A and write B.
// Define MEM_SEQ_AUTO_RESTART_EN to chain runs back to back after done.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DFLT,
  parameter int CNT_W   = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  output logic wea,
  output logic inca,
  output logic clr_a,
  output logic ld_x,
  output logic ld_y,
  output logic web,
  output logic incb,
  output logic clr_b,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(N_WORDS / 2 - 1);

  state_t state;
  state_t state_d;

  logic w_clr;
  logic w_inc;
  logic w_tc;
  logic p_clr;
  logic p_inc;
  logic p_tc;

  mem_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_wcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .inc  (w_inc),
    .last (W_LAST),
    .tc   (w_tc)
  );

  mem_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_pcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (p_clr),
    .inc  (p_inc),
    .last (P_LAST),
    .tc   (p_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    wea      = 1'b0;
    inca     = 1'b0;
    clr_a    = 1'b0;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    web      = 1'b0;
    incb     = 1'b0;
    clr_b    = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    p_clr    = 1'b0;
    p_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        clr_a   = 1'b1;
        clr_b   = 1'b1;
        w_clr   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        wea      = in_valid;
        inca     = in_valid;
        w_inc    = in_valid;
        if (in_valid && w_tc) state_d = RWND;
      end
      RWND: begin
        clr_a   = 1'b1;
        p_clr   = 1'b1;
        state_d = RDX;
      end
      RDX: begin
        ld_x    = 1'b1;
        inca    = 1'b1;
        state_d = RDY;
      end
      RDY: begin
        ld_y    = 1'b1;
        inca    = 1'b1;
        state_d = WRB;
      end
      WRB: begin
        web     = 1'b1;
        state_d = NXT;
      end
      NXT: begin
        incb    = 1'b1;
        p_inc   = 1'b1;
        state_d = p_tc ? DONE : RDX;
      end
      DONE: begin
        done = 1'b1;
`ifdef MEM_SEQ_AUTO_RESTART_EN
        state_d = CLR;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: random and directed runs checked cycle by cycle
// against a phase-level model of the sequencer.
module tb_mem_seq_ctrl;

  localparam int N = 8;

  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_LOAD = 2;
  localparam int P_READ = 3;

  localparam int B_RDY  = 10;
  localparam int B_WEA  = 9;
  localparam int B_INCA = 8;
  localparam int B_CLRA = 7;
  localparam int B_LDX  = 6;
  localparam int B_LDY  = 5;
  localparam int B_WEB  = 4;
  localparam int B_INCB = 3;
  localparam int B_CLRB = 2;
  localparam int B_BUSY = 1;
  localparam int B_DONE = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic wea;
  logic inca;
  logic clr_a;
  logic ld_x;
  logic ld_y;
  logic web;
  logic incb;
  logic clr_b;
  logic busy;
  logic done;

  int nchk = 0;
  int nbad = 0;

  int ph = P_IDLE;
  int loaded = 0;
  int k = 0;
  int stalls = 0;
  int cyc_n = 0;
  int t_start = 0;
  int t_clr = 0;
  int ndone = 0;
  int last_done = 0;
  int c_wea = 0;
  int c_inca = 0;
  int c_web = 0;
  int c_incb = 0;
  int c_clra = 0;
  int c_clrb = 0;

  mem_seq_ctrl #(
    .N_WORDS (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wea      (wea),
    .inca     (inca),
    .clr_a    (clr_a),
    .ld_x     (ld_x),
    .ld_y     (ld_y),
    .web      (web),
    .incb     (incb),
    .clr_b    (clr_b),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [10:0] obs_vec();
    return {in_ready, wea, inca, clr_a, ld_x, ld_y,
            web, incb, clr_b, busy, done};
  endfunction

  // Read phase: k=0 rewind, then 4 cycles per pair, then done.
  function automatic logic [10:0] exp_vec();
    logic [10:0] e;
    int j;
    e = '0;
    j = 0;
    case (ph)
      P_CLR: begin
        e[B_CLRA] = 1'b1;
        e[B_CLRB] = 1'b1;
      end
      P_LOAD: begin
        e[B_RDY]  = 1'b1;
        e[B_WEA]  = in_valid;
        e[B_INCA] = in_valid;
      end
      P_READ: begin
        if (k == 0) begin
          e[B_CLRA] = 1'b1;
        end else if (k > 2 * N) begin
          e[B_DONE] = 1'b1;
        end else begin
          j = (k - 1) % 4;
          if (j == 0) begin
            e[B_LDX]  = 1'b1;
            e[B_INCA] = 1'b1;
          end else if (j == 1) begin
            e[B_LDY]  = 1'b1;
            e[B_INCA] = 1'b1;
          end else if (j == 2) begin
            e[B_WEB] = 1'b1;
          end else begin
            e[B_INCB] = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (ph != P_IDLE) e[B_BUSY] = 1'b1;
    return e;
  endfunction

  task automatic check_cycle();
    logic [10:0] e;
    logic [10:0] o;
    e = exp_vec();
    o = obs_vec();
    chk("outs", 32'(o), 32'(e));
    if (ph == P_CLR) begin
      c_wea  = 0;
      c_inca = 0;
      c_web  = 0;
      c_incb = 0;
      c_clra = 0;
      c_clrb = 0;
    end
    c_wea  += int'(o[B_WEA]);
    c_inca += int'(o[B_INCA]);
    c_web  += int'(o[B_WEB]);
    c_incb += int'(o[B_INCB]);
    c_clra += int'(o[B_CLRA]);
    c_clrb += int'(o[B_CLRB]);
    if (e[B_DONE]) begin
      ndone++;
      last_done = cyc_n;
      chk("run_wea", 32'(c_wea), 32'(N));
      chk("run_inca", 32'(c_inca), 32'(2 * N));
      chk("run_web", 32'(c_web), 32'(N / 2));
      chk("run_incb", 32'(c_incb), 32'(N / 2));
      chk("run_clra", 32'(c_clra), 32'(2));
      chk("run_clrb", 32'(c_clrb), 32'(1));
      chk("run_lat", 32'(cyc_n - t_clr), 32'(2 + 3 * N + stalls));
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      ph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE: begin
          if (start) begin
            ph = P_CLR;
            t_start = cyc_n;
          end
        end
        P_CLR: begin
          ph = P_LOAD;
          loaded = 0;
          stalls = 0;
          t_clr = cyc_n;
        end
        P_LOAD: begin
          if (in_valid) loaded++;
          else stalls++;
          if (loaded == N) begin
            ph = P_READ;
            k = 0;
          end
        end
        P_READ: begin
          k++;
          if (k > 2 * N + 1) begin
`ifdef MEM_SEQ_AUTO_RESTART_EN
            ph = P_CLR;
`else
            ph = P_IDLE;
`endif
          end
        end
        default: ph = P_IDLE;
      endcase
    end
    cyc_n++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic wait_done(input int maxc);
    int d0;
    int i;
    d0 = ndone;
    i = 0;
    while (ndone == d0 && i < maxc) begin
      cyc(1);
      i++;
    end
    chk("done_seen", 32'(ndone != d0), 32'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int i;
    int d0;

    // 1: reset then quiet idle
    do_reset();
    cyc(10);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_outs", 32'(obs_vec()), 32'(0));

    // 2: clean run, in_valid always high
    do_reset();
    in_valid = 1'b1;
    pulse_start();
    wait_done(100);
    chk("lat_clean", 32'(last_done - t_start), 32'(27));

    // 3: three-cycle input stall after the fourth word
    do_reset();
    in_valid = 1'b1;
    pulse_start();
    i = 0;
    while (!(ph == P_LOAD && loaded == 4) && i < 50) begin
      cyc(1);
      i++;
    end
    chk("stall_reach", 32'(loaded), 32'(4));
    in_valid = 1'b0;
    cyc(3);
    in_valid = 1'b1;
    wait_done(100);
    chk("lat_stall", 32'(last_done - t_start), 32'(30));

    // 4: start held, in_valid toggling during read phase
    do_reset();
    in_valid = 1'b1;
    start = 1'b1;
    d0 = ndone;
    i = 0;
    while (ph != P_READ && i < 50) begin
      cyc(1);
      i++;
    end
    while (ndone == d0 && i < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      cyc(1);
      i++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    cyc(3);
    chk("held_one_done", 32'(ndone - d0), 32'(1));
`ifdef MEM_SEQ_AUTO_RESTART_EN
    chk("held_busy", 32'(busy), 32'(1));
`else
    chk("held_busy", 32'(busy), 32'(0));
`endif

    // 5: reset in WRB of the second pair, then a fresh run
    do_reset();
    in_valid = 1'b1;
    pulse_start();
    i = 0;
    while (!(ph == P_READ && k == 7) && i < 60) begin
      cyc(1);
      i++;
    end
    chk("wrb2_web", 32'(web), 32'(1));
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk("abort_outs", 32'(obs_vec()), 32'(0));
    cyc(2);
    chk("abort_idle", 32'(busy), 32'(0));
    pulse_start();
    wait_done(100);
    chk("lat_fresh", 32'(last_done - t_start), 32'(27));

    // 6: random start, in_valid and occasional reset
    do_reset();
    d0 = ndone;
    for (int r = 0; r < 600; r++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    rst = 1'b1;
    start = 1'b0;
    chk("rand_runs", 32'(ndone > d0), 32'(1));

`ifdef MEM_SEQ_AUTO_RESTART_EN
    // auto restart: one start gives back-to-back runs
    do_reset();
    in_valid = 1'b1;
    d0 = ndone;
    pulse_start();
    wait_done(100);
    wait_done(100);
    wait_done(100);
    chk("auto_runs", 32'(ndone - d0), 32'(3));
`endif

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
